// File: rtl/uart_rx_core.sv
// UART 8N1 receiver fed by the auto-baud count; one-deep holding register with FERR/OERR.
// Define UART_PARITY_EN to insert a parity bit (PARITY state) and add the PERR output.
module uart_rx_core #(
    parameter int               CNT_W       = 16,
    parameter logic [CNT_W-1:0] BIT_DEFAULT = 16'd434
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             UxRX,
    input  logic             ABAUD,
    input  logic             brg_ld,
    input  logic [CNT_W-1:0] brg_cnt,
    input  logic             rd,
    input  logic             oerr_clr,
    output logic [7:0]       UxRXREG,
    output logic             URXDA,
    output logic             UxRXIF,
    output logic             FERR,
`ifdef UART_PARITY_EN
    output logic             PERR,
`endif
    output logic             OERR
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t           state_reg, state_next;
    logic             rx_meta_reg, rx_s_reg;
    logic [CNT_W-1:0] bit_period_reg, brg_div;
    logic [CNT_W-1:0] tmr_reg, tmr_next;
    logic [2:0]       idx_reg, idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic             tmr_event, commit;
    logic [7:0]       rxreg_reg;
    logic             urxda_reg, rxif_reg, ferr_reg, oerr_reg;
`ifdef UART_PARITY_EN
    logic             par_bit_reg, par_bit_next;
    logic             perr_reg;
    assign PERR = perr_reg;
`endif

    assign UxRXREG   = rxreg_reg;
    assign URXDA     = urxda_reg;
    assign UxRXIF    = rxif_reg;
    assign FERR      = ferr_reg;
    assign OERR      = oerr_reg;
    assign tmr_event = (tmr_reg == CNT_W'(1));
    assign brg_div   = brg_cnt >> 3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= UxRX;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    // A new rate is only accepted while no frame is in flight (or auto-baud owns the line).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_period_reg <= BIT_DEFAULT;
        end else if (brg_ld && (state_reg == S_IDLE || ABAUD)) begin
            bit_period_reg <= (brg_div < CNT_W'(2)) ? CNT_W'(2) : brg_div;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= S_IDLE;
            tmr_reg     <= '0;
            idx_reg     <= '0;
            shift_reg   <= '0;
`ifdef UART_PARITY_EN
            par_bit_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            tmr_reg     <= tmr_next;
            idx_reg     <= idx_next;
            shift_reg   <= shift_next;
`ifdef UART_PARITY_EN
            par_bit_reg <= par_bit_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        tmr_next     = tmr_reg;
        idx_next     = idx_reg;
        shift_next   = shift_reg;
        commit       = 1'b0;
`ifdef UART_PARITY_EN
        par_bit_next = par_bit_reg;
`endif
        if (state_reg != S_IDLE && state_reg != S_BREAK && !tmr_event)
            tmr_next = tmr_reg - CNT_W'(1);
        case (state_reg)
            S_IDLE: begin
                if (!rx_s_reg) begin
                    state_next = S_START;
                    tmr_next   = bit_period_reg >> 1;
                end
            end
            S_START: begin
                if (tmr_event) begin
                    if (rx_s_reg) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_DATA;
                        idx_next   = 3'd0;
                        tmr_next   = bit_period_reg;
                    end
                end
            end
            S_DATA: begin
                if (tmr_event) begin
                    shift_next = {rx_s_reg, shift_reg[7:1]};
                    tmr_next   = bit_period_reg;
                    idx_next   = idx_reg + 3'd1;
                    if (idx_reg == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (tmr_event) begin
                    par_bit_next = rx_s_reg;
                    state_next   = S_STOP;
                    tmr_next     = bit_period_reg;
                end
            end
`endif
            S_STOP: begin
                if (tmr_event) begin
                    commit     = 1'b1;
                    state_next = rx_s_reg ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (rx_s_reg) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        // Auto-baud overrides everything, including a frame about to commit.
        if (ABAUD) begin
            state_next = S_IDLE;
            commit     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxreg_reg <= '0;
            urxda_reg <= 1'b0;
            rxif_reg  <= 1'b0;
            ferr_reg  <= 1'b0;
            oerr_reg  <= 1'b0;
`ifdef UART_PARITY_EN
            perr_reg  <= 1'b0;
`endif
        end else begin
            rxif_reg <= commit;
            if (oerr_clr) oerr_reg <= 1'b0;
            if (commit) begin
                if (!urxda_reg || rd) begin
                    rxreg_reg <= shift_reg;
                    urxda_reg <= 1'b1;
                    ferr_reg  <= ~rx_s_reg;
`ifdef UART_PARITY_EN
                    perr_reg  <= ^{shift_reg, par_bit_reg};
`endif
                end else begin
                    oerr_reg <= 1'b1;
                end
            end else if (rd) begin
                urxda_reg <= 1'b0;
            end
        end
    end

endmodule
